// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bus host interface.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Word registers: the two byte-address LSBs must be zero for a hit.
  localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/reg_bus_host_if_if.sv
// Host request/response channel plus register-strobe side of the register bus.
interface reg_bus_host_if_if #(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [AW-1:0]         req_addr_i;
  logic [DW-1:0]         req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DW-1:0]         rsp_rdata_o;
  logic                  rsp_err_o;
  logic [NumRegs-1:0]    reg_we_o;
  logic [NumRegs-1:0]    reg_re_o;
  logic [DW-1:0]         reg_wd_o;
  logic [NumRegs*DW-1:0] reg_qs_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i, reg_qs_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, reg_we_o, reg_re_o, reg_wd_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i, reg_qs_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, reg_we_o, reg_re_o, reg_wd_o
  );
endinterface

// File: rtl/reg_bus_host_if.sv
// Single-outstanding host bridge: accept a request, strobe one register for a cycle,
// then hold the response until the host takes it.
module reg_bus_host_if
  import reg_bus_pkg::*;
#(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  reg_bus_host_if_if.slave bus
);

  localparam int unsigned IW = AW - ALIGN_BITS;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_in_hit;
  logic [IW-1:0]      w_in_idx;
  logic [NumRegs-1:0] w_in_onehot;
  logic [DW-1:0]      w_rd_mux;

  logic               r_write;
  logic               r_hit;
  logic [IW-1:0]      r_idx;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DW-1:0]      r_rsp_rdata;
  logic [DW-1:0]      r_reg_wd;
  logic [NumRegs-1:0] r_reg_we;
  logic [NumRegs-1:0] r_reg_re;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid_i;
  assign w_in_idx = bus.req_addr_i[AW-1:ALIGN_BITS];
  assign w_in_hit = (bus.req_addr_i[ALIGN_BITS-1:0] == '0) && (32'(w_in_idx) < NumRegs);

  // Strobe decode on the incoming address, read mux on the latched index.
  always_comb begin
    w_in_onehot = '0;
    w_rd_mux    = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      w_in_onehot[i] = (w_in_idx == IW'(i));
      if (r_idx == IW'(i)) w_rd_mux = bus.reg_qs_i[i*DW +: DW];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.req_valid_i) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // Strobes are loaded at the accept edge so they are live only during ACCESS.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_write     <= 1'b0;
      r_hit       <= 1'b0;
      r_idx       <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_reg_wd    <= '0;
      r_reg_we    <= '0;
      r_reg_re    <= '0;
    end else begin
      r_reg_wd <= '0;
      r_reg_we <= '0;
      r_reg_re <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write_i;
            r_hit    <= w_in_hit;
            r_idx    <= w_in_idx;
            r_reg_wd <= bus.req_wdata_i;
            if (w_in_hit && bus.req_write_i)  r_reg_we <= w_in_onehot;
            if (w_in_hit && !bus.req_write_i) r_reg_re <= w_in_onehot;
          end
        end
        ST_ACCESS: begin
          r_rsp_err   <= !r_hit;
          r_rsp_rdata <= (r_hit && !r_write) ? w_rd_mux : '0;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.reg_we_o    = r_reg_we;
  assign bus.reg_re_o    = r_reg_re;
  assign bus.reg_wd_o    = r_reg_wd;

endmodule

// File: doc/reg_bus_host_if.md
REG_BUS_HOST_IF -- requirements
Module: reg_bus_host_if

Interface
REQ-001 SHALL have parameter NumRegs, default 8, number of word registers served (1..64).
REQ-002 SHALL have parameter AW, default 8, byte-address width; SHALL satisfy AW >= clog2(NumRegs)+2.
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  1  host request valid.
REQ-007 req_ready_o  output  1  block can accept request.
REQ-008 req_write_i  input  1  1 = write, 0 = read.
REQ-009 req_addr_i  input  AW  byte address.
REQ-010 req_wdata_i  input  DW  write data.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  host accepts response.
REQ-013 rsp_rdata_o  output  DW  read data; zero for writes and errors.
REQ-014 rsp_err_o  output  1  unmapped or misaligned access.
REQ-015 reg_we_o  output  NumRegs  one-hot write pulse per register (drives register-primitive we).
REQ-016 reg_re_o  output  NumRegs  one-hot read pulse per register (drives we of read-to-clear registers).
REQ-017 reg_wd_o  output  DW  write data to all registers.
REQ-018 reg_qs_i  input  NumRegs*DW  software-view values; register i at bits [i*DW +: DW].

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-020 IDLE: req_ready_o=1; on req_valid_i&req_ready_o SHALL latch write, addr, wdata and go to ACCESS; otherwise stay.
REQ-021 ACCESS and RESP: req_ready_o SHALL be 0.
REQ-022 Index = latched addr[AW-1:2]; hit SHALL mean addr[1:0]==0 and index < NumRegs.
REQ-023 ACCESS (exactly one cycle): on hit&write SHALL assert reg_we_o[index] with reg_wd_o = latched wdata; on hit&read SHALL assert reg_re_o[index] and capture reg_qs_i[index] into rsp_rdata; on miss SHALL assert no strobe and set err=1; then go to RESP.
REQ-024 Read data SHALL be sampled in the ACCESS cycle, so a read-to-clear register returns its pre-clear value.
REQ-025 reg_we_o and reg_re_o SHALL be zero in all cycles except ACCESS; at most one bit of the combined strobes SHALL be set.
REQ-026 reg_wd_o SHALL equal the latched wdata in ACCESS and zero otherwise.
REQ-027 RESP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable until rsp_ready_i; on rsp_valid_o&rsp_ready_i SHALL go to IDLE.
REQ-028 Latency: request accepted at edge N, strobe during cycle N+1, rsp_valid_o first high in cycle N+2; max throughput one transaction per 3 cycles.
REQ-029 A request held on req_valid_i while not ready SHALL NOT be sampled; the next request is accepted only in IDLE.

Reset
REQ-030 rst_i high at an edge SHALL force IDLE and clear all latched request and response state, including mid-transaction; the pending response SHALL be discarded.
REQ-031 During/after reset: req_ready_o=1 (IDLE), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, reg_we_o=0, reg_re_o=0, reg_wd_o=0.

Structure
REQ-032 Package reg_bus_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the alignment constant (2 address LSBs).
REQ-033 No sub-module; decode and read-mux SHALL be inline.

Verification
REQ-034 Write 0xDEADBEEF to addr 0x08 -> reg_we_o=0b00000100 for one cycle with reg_wd_o=0xDEADBEEF; response err=0, rdata=0, two cycles after accept.
REQ-035 Read addr 0x0C with reg_qs_i[3]=0x1234 -> reg_re_o=0b00001000 for one cycle, rsp_rdata_o=0x1234, err=0.
REQ-036 Read addr 0x20 (index 8) and addr 0x05 (misaligned) -> no strobes, rsp_err_o=1, rsp_rdata_o=0.
REQ-037 Hold rsp_ready_i=0 for 5 cycles with a second req_valid_i asserted -> response stable, req_ready_o=0, second request accepted only after response handshake.
REQ-038 Assert rst_i during ACCESS and during RESP -> next cycle IDLE, all outputs at reset values, no response issued.
